// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: operation modes and FSM states.
// Latency: n/a. Backpressure: n/a.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        HOLD  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-position combinational shift/rotate of value according to mode.
// Latency: combinational. Backpressure: none.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  mode_t            mode,
    output logic [WIDTH-1:0] next_value,
    output logic             carry
);

    always_comb begin
        next_value = value;
        carry      = 1'b0;
        case (mode)
            MODE_SLL: begin
                next_value = {value[WIDTH-2:0], 1'b0};
                carry      = value[WIDTH-1];
            end
            MODE_SRL: begin
                next_value = {1'b0, value[WIDTH-1:1]};
                carry      = value[0];
            end
            MODE_SRA: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                carry      = value[0];
            end
            MODE_ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                carry      = value[0];
            end
            default: begin
                next_value = value;
                carry      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/param_shift_unit.sv
// Iterative shifter: one position per clock, count loaded from shamt on accept.
// Latency: result valid shamt edges after the accept edge. Backpressure: result held until out_ready; no new accept until then.
module param_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work;
    logic             carry_q;
    mode_t            mode_q;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] step_val;
    logic             step_carry;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .value      (work),
        .mode       (mode_q),
        .next_value (step_val),
        .carry      (step_carry)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leave SHIFT on the edge that performs the last step (count still 1).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (shamt == '0) ? HOLD : SHIFT;
                end
            end
            SHIFT: begin
                if (count == SHW'(1)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work    <= '0;
            carry_q <= 1'b0;
            mode_q  <= MODE_SLL;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work    <= data_in;
                        carry_q <= 1'b0;
                        mode_q  <= mode_t'(mode);
                        count   <= shamt;
                    end
                end
                SHIFT: begin
                    work    <= step_val;
                    carry_q <= step_carry;
                    count   <= count - SHW'(1);
                end
                default: begin
                    work    <= work;
                    carry_q <= carry_q;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign result    = work;
    assign carry_out = carry_q;
    assign zero      = (work == '0);

endmodule

// File: tb/tb_param_shift_unit.sv
// Scoreboard bench for param_shift_unit: directed cases plus random traffic vs. arithmetic model.
module tb_param_shift_unit;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_in;
    logic [2:0]   shamt;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        int           s;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic hold_low = 1'b0;
    logic prev_vld = 1'b0;

    param_shift_unit #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shamt     (shamt),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Whole-operand reference: the shift is done in one go, carry is the last bit to leave.
    function automatic exp_t model(input logic [W-1:0] d, input int s, input logic [1:0] m);
        exp_t               e;
        logic signed [W-1:0] sd;
        int                 lo;
        int                 hi;
        sd = d;
        lo = (s > 0) ? s - 1 : 0;
        hi = (s > 0) ? W - s : 0;
        e.s   = s;
        e.acc = 0;
        case (m)
            2'b00: begin e.r = d << s;                    e.c = (s > 0) ? d[hi] : 1'b0; end
            2'b01: begin e.r = d >> s;                    e.c = (s > 0) ? d[lo] : 1'b0; end
            2'b10: begin e.r = sd >>> s;                  e.c = (s > 0) ? d[lo] : 1'b0; end
            default: begin e.r = (d >> s) | (d << (W - s)); e.c = (s > 0) ? d[lo] : 1'b0; end
        endcase
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] d, input int s, input logic [1:0] m, input bit push);
        exp_t e;
        bit   got;
        got = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b1;
        data_in  = d;
        shamt    = 3'(s);
        mode     = m;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_timeout", {31'd0, got}, 32'd1);
        if (got) begin
            @(posedge clock);
            #1;
            e     = model(d, s, m);
            e.acc = cyc;
            if (push) sb.push_back(e);
        end
        in_valid = 1'b0;
        data_in  = W'($urandom);
        shamt    = 3'($urandom);
        mode     = 2'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (out_valid) begin
                chk("in_ready_in_hold", {31'd0, in_ready}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_output", {24'd0, result}, 32'hFFFF_FFFF);
                end else begin
                    e = sb[0];
                    chk("result", {24'd0, result}, {24'd0, e.r});
                    chk("carry_out", {31'd0, carry_out}, {31'd0, e.c});
                    chk("zero", {31'd0, zero}, {31'd0, (e.r == '0)});
                    if (!prev_vld) chk("latency", cyc - e.acc, e.s);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_vld = out_valid;
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        shamt    = '0;
        mode     = 2'b00;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_carry", {31'd0, carry_out}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        issue(8'h81, 1, 2'b00, 1'b1);
        issue(8'h90, 3, 2'b10, 1'b1);
        issue(8'h01, 7, 2'b11, 1'b1);
        @(posedge clock);
        @(negedge clock);
        chk("ror_first_step", {24'd0, result}, 32'h80);
        drain();

        // Result held under backpressure while a stray request is offered.
        @(negedge clock);
        hold_low = 1'b1;
        issue(8'hA5, 0, 2'b01, 1'b1);
        in_valid = 1'b1;
        data_in  = 8'h00;
        shamt    = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_result", {24'd0, result}, 32'hA5);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        hold_low = 1'b0;
        drain();

        issue(8'h01, 1, 2'b01, 1'b1);
        drain();

        // Reset in the middle of a shift discards the operation.
        issue(8'hFF, 7, 2'b01, 1'b0);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", {24'd0, result}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_zero", {31'd0, zero}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        issue(8'h01, 2, 2'b00, 1'b1);
        drain();

        for (int n = 0; n < 40; n++) begin
            issue(W'($urandom), $urandom_range(0, W - 1), 2'($urandom), 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
